// File: rtl/led_pwm_bank_pkg.sv
// Shared constants and percent arithmetic for the LED PWM bank.
package led_pwm_bank_pkg;

  localparam logic [1:0] MODE_STEADY   = 2'b00;
  localparam logic [1:0] MODE_ACTIVITY = 2'b01;
  localparam logic [1:0] MODE_BLINK    = 2'b10;
  localparam logic [1:0] MODE_BREATHE  = 2'b11;

  localparam int unsigned PCT_MAX   = 100;
  localparam int unsigned PWM_STEPS = 100;
  localparam int unsigned PCT_W     = 7;

  function automatic logic [PCT_W-1:0] pct_clamp(input logic [PCT_W-1:0] v);
    return (v > PCT_W'(PCT_MAX)) ? PCT_W'(PCT_MAX) : v;
  endfunction

  // a*b/100, truncated; both operands must already be within 0..100.
  function automatic logic [PCT_W-1:0] pct_scale(input logic [PCT_W-1:0] a,
                                                 input logic [PCT_W-1:0] b);
    logic [13:0] prod;
    prod = {7'd0, a} * {7'd0, b};
    return PCT_W'(prod / 14'(PCT_MAX));
  endfunction

endpackage

// File: rtl/led_pwm_bank_if.sv
// Per-channel control and LED output bundle for led_pwm_bank.
interface led_pwm_bank_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0]   enable;
  logic [7*CHANNELS-1:0] level;
  logic [7*CHANNELS-1:0] cal;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   activity;
  logic [CHANNELS-1:0]   led;

  modport master (output enable, level, cal, mode, activity, input led);
  modport slave  (input enable, level, cal, mode, activity, output led);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: duty math and frame latch, activity stretch, mode gate, PWM output flop.
module led_pwm_channel
  import led_pwm_bank_pkg::*;
#(
  parameter int unsigned HOLD_MS = 20
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             tick_ms_i,
  input  logic             frame_start_i,
  input  logic [PCT_W-1:0] phase_i,
  input  logic             blink_i,
  input  logic [PCT_W-1:0] ramp_i,
  input  logic             enable_i,
  input  logic [PCT_W-1:0] level_i,
  input  logic [PCT_W-1:0] cal_i,
  input  logic [1:0]       mode_i,
  input  logic             activity_i,
  output logic             led_o
);

  localparam int unsigned HOLD_W = $clog2(HOLD_MS + 1);

  logic [PCT_W-1:0]  duty_base;
  logic [PCT_W-1:0]  duty_d, duty_q;
  logic [2:0]        sync_d, sync_q;
  logic [HOLD_W-1:0] hold_d, hold_q;
  logic              act_rise;
  logic              gate;
  logic              led_d, led_q;

  always_comb begin
    duty_base = pct_scale(pct_clamp(level_i), pct_clamp(cal_i));
    duty_d    = duty_q;
    if (frame_start_i) begin
      duty_d = (mode_i == MODE_BREATHE) ? pct_scale(duty_base, ramp_i) : duty_base;
    end

    // Bits [1:0] synchronise; bit 2 is the previous synchronised value for edge detect.
    sync_d   = {sync_q[1:0], activity_i};
    act_rise = sync_q[1] & ~sync_q[2];

    hold_d = hold_q;
    if (mode_i != MODE_ACTIVITY) begin
      hold_d = '0;
    end else if (act_rise) begin
      hold_d = HOLD_W'(HOLD_MS);
    end else if (tick_ms_i && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
    end

    gate = 1'b1;
    unique case (mode_i)
      MODE_STEADY:   gate = 1'b1;
      MODE_ACTIVITY: gate = (hold_q != '0);
      MODE_BLINK:    gate = blink_i;
      MODE_BREATHE:  gate = 1'b1;
      default:       gate = 1'b1;
    endcase

    led_d = enable_i & gate & (phase_i < duty_q);
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      duty_q <= '0;
      sync_q <= '0;
      hold_q <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      sync_q <= sync_d;
      hold_q <= hold_d;
      led_q  <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_pwm_bank.sv
// LED PWM bank: shared ms tick, PWM phase, blink toggle and breathe ramp driving N channels.
module led_pwm_bank
  import led_pwm_bank_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CLK_MHZ    = 21,
  parameter int unsigned PWM_DIV    = 64,
  parameter int unsigned HOLD_MS    = 20,
  parameter int unsigned BLINK_MS   = 250,
  parameter int unsigned BREATHE_MS = 10
) (
  input logic           clock,
  input logic           nReset,
  led_pwm_bank_if.slave bus_io
);

  localparam int unsigned MS_CYCLES = CLK_MHZ * 1000;
  localparam int unsigned MS_W      = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam int unsigned PRE_W     = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int unsigned BLINK_W   = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int unsigned BR_W      = (BREATHE_MS > 1) ? $clog2(BREATHE_MS) : 1;

  logic [MS_W-1:0]    ms_d, ms_q;
  logic [PRE_W-1:0]   pre_d, pre_q;
  logic [PCT_W-1:0]   phase_d, phase_q;
  logic [BLINK_W-1:0] blink_cnt_d, blink_cnt_q;
  logic               blink_d, blink_q;
  logic [BR_W-1:0]    br_cnt_d, br_cnt_q;
  logic [PCT_W-1:0]   ramp_d, ramp_q;
  logic               ramp_up_d, ramp_up_q;
  logic               tick_ms, pwm_step, frame_start, br_step;
  logic [CHANNELS-1:0] led_w;

  always_comb begin
    tick_ms = (ms_q == MS_W'(MS_CYCLES - 1));
    ms_d    = tick_ms ? '0 : ms_q + MS_W'(1);

    pwm_step    = (pre_q == PRE_W'(PWM_DIV - 1));
    pre_d       = pwm_step ? '0 : pre_q + PRE_W'(1);
    frame_start = pwm_step && (phase_q == PCT_W'(PWM_STEPS - 1));
    phase_d     = phase_q;
    if (pwm_step) begin
      phase_d = frame_start ? '0 : phase_q + PCT_W'(1);
    end

    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (tick_ms) begin
      if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    br_step  = tick_ms && (br_cnt_q == BR_W'(BREATHE_MS - 1));
    br_cnt_d = br_cnt_q;
    if (tick_ms) begin
      br_cnt_d = br_step ? '0 : br_cnt_q + BR_W'(1);
    end

    // The turning step only flips direction, so each endpoint lasts one extra step.
    ramp_d    = ramp_q;
    ramp_up_d = ramp_up_q;
    if (br_step) begin
      if (ramp_up_q) begin
        if (ramp_q == PCT_W'(PCT_MAX)) ramp_up_d = 1'b0;
        else                           ramp_d    = ramp_q + PCT_W'(1);
      end else begin
        if (ramp_q == '0) ramp_up_d = 1'b1;
        else              ramp_d    = ramp_q - PCT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ms_q        <= '0;
      pre_q       <= '0;
      phase_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      br_cnt_q    <= '0;
      ramp_q      <= '0;
      ramp_up_q   <= 1'b1;
    end else begin
      ms_q        <= ms_d;
      pre_q       <= pre_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      br_cnt_q    <= br_cnt_d;
      ramp_q      <= ramp_d;
      ramp_up_q   <= ramp_up_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    led_pwm_channel #(
      .HOLD_MS(HOLD_MS)
    ) u_ch (
      .clock        (clock),
      .nReset       (nReset),
      .tick_ms_i    (tick_ms),
      .frame_start_i(frame_start),
      .phase_i      (phase_q),
      .blink_i      (blink_q),
      .ramp_i       (ramp_q),
      .enable_i     (bus_io.enable[g]),
      .level_i      (bus_io.level[7*g +: 7]),
      .cal_i        (bus_io.cal[7*g +: 7]),
      .mode_i       (bus_io.mode[2*g +: 2]),
      .activity_i   (bus_io.activity[g]),
      .led_o        (led_w[g])
    );
  end

  assign bus_io.led = led_w;

endmodule
